alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: Parameter RR_EN, default 1, 1 = round-robin grant, 0 = fixed priority to requester 0.
REQ-002: clk  input  1  single clock; all state updates on rising edge.
REQ-003: rst_n  input  1  asynchronous, active-low reset.
REQ-004: req0_valid  input  1  requester 0 holds a valid operation.
REQ-005: req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006: req0_a, req0_b  input  16 each  requester 0 operands.
REQ-007: req0_op  input  4  requester 0 opcode (ALU encoding 0000-1011).
REQ-008: req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths and meanings for requester 1.
REQ-009: rsp_valid  output  1  registered response available.
REQ-010: rsp_ready  input  1  consumer accepts response when high with rsp_valid.
REQ-011: rsp_id  output  1  index of the requester that issued the response.
REQ-012: rsp_result  output  16  registered ALU result.
REQ-013: rsp_err  output  1  opcode was 1100-1111 (unsupported).
REQ-014: flags  output  3  architectural flag register {N,Z,V}, bit 2 = N, bit 1 = Z, bit 0 = V.

Function
REQ-015: Accept condition: slot_free = !rsp_valid | rsp_ready; at most one requester accepted per cycle, only when slot_free.
REQ-016: Grant: only one valid -> that one; both valid, RR_EN=1 -> requester not granted last; RR_EN=0 -> requester 0.
REQ-017: last_grant updates only on an actual accept; holds otherwise.
REQ-018: reqN_ready = slot_free & grant_N, combinational; ready of a non-valid requester is 0.
REQ-019: Granted operands/opcode drive the single shared ALU combinationally; result, id and err registered into the response slot at the accept edge.
REQ-020: Latency: accept at edge N -> rsp_valid high after edge N, i.e. one cycle; back-to-back accepts give one response per cycle when rsp_ready stays high.
REQ-021: Response slot holds rsp_result, rsp_id, rsp_err stable while rsp_valid & !rsp_ready.
REQ-022: rsp_valid clears on rsp_ready unless a new accept occurs in the same cycle (then it stays set with new data).
REQ-023: Flag update at accept edge: ops 0000/0001 write N, Z, V from ALU flags; ops 0010/0100/0101/0110 write Z only; all other ops leave flags unchanged.
REQ-024: Unsupported op 1100-1111: accepted normally, rsp_result = 16'h0000, rsp_err = 1, flags unchanged.
REQ-025: Requesters must hold valid/operands until ready; block behaviour with valid dropped before acceptance is don't-care for that operation but must not corrupt the slot.
REQ-026: Arithmetic and width rules are entirely those of the ALU; no extension or truncation in this block.

Reset
REQ-027: On rst_n low, immediately: rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_err = 0, flags = 3'b000, last_grant = 1 (requester 0 wins first tie).
REQ-028: Reset mid-operation discards the pending response; no request is accepted while rst_n is low (ready = 0).
REQ-029: First accept possible on the first rising edge after rst_n deasserts.

Structure
REQ-030: Opcode constants (ADD..LHB, 0000-1011), flag bit indices, and the Z-updating/NV-updating op sets belong in the shared ISA package.
REQ-031: One sub-module: the existing alu, instantiated once; all arbitration, slot and flag logic live in alu_arbiter.

Verification
REQ-032: Req0 ADD a=16'h7FFF b=16'h0001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=16'h8000, flags=3'b101.
REQ-033: Both valid continuously (req0 XOR 16'h00FF^16'h00FF, req1 ADD 1+2), rsp_ready=1 -> responses alternate id 0,1,0,1; first is id 0, result 0, Z=1; then id 1, result 3, flags=3'b000.
REQ-034: rsp_ready=0 for 3 cycles after one accept -> rsp_* stable, both reqN_ready=0, flags unchanged; rsp_ready=1 with pending req1 -> new response next cycle, no bubble.
REQ-035: SUB 5-5 (flags=3'b010), then LLB a=16'h1234 b=16'h00AB -> rsp_result=16'h12AB, flags remain 3'b010; then op 1111 -> rsp_err=1, rsp_result=0, flags 3'b010.
REQ-036: RR_EN=0, both valid 4 cycles -> all four responses id 0, req1_ready stays 0.
REQ-037: Assert rst_n low while rsp_valid=1 -> rsp_valid and flags drop to 0 without a clock edge; after release, tie grants requester 0.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared ISA definitions: opcodes, flag bit positions, and which ops write which flags.
package alu_arbiter_pkg;

    localparam int DATA_W = 16;
    localparam int OP_W   = 4;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LLB    = 4'b1010,
        OP_LHB    = 4'b1011
    } alu_op_e;

    function automatic logic is_nv_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_z_op(input logic [OP_W-1:0] op);
        return (op == OP_XOR) || (op == OP_SLL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 16-bit ALU: result plus candidate {N,Z,V}; opcodes 1100-1111 flag err.
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic [2:0]        alu_flags,
    output logic              err
);

    // Signed nibble add, saturating to the 4-bit range [-8, 7].
    function automatic logic [3:0] sat_add4(input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        s = {x[3], x} + {y[3], y};
        case (s[4:3])
            2'b01:   return 4'h7;
            2'b10:   return 4'h8;
            default: return s[3:0];
        endcase
    endfunction

    logic [DATA_W-1:0] add_res;
    logic [DATA_W-1:0] sub_res;
    logic              add_v;
    logic              sub_v;
    logic [9:0]        red_sum;
    logic [31:0]       rot_wide;
    logic [DATA_W-1:0] paddsb_res;
    logic [3:0]        sh;
    logic              v;

    assign sh      = b[3:0];
    assign add_res = a + b;
    assign sub_res = a - b;
    assign add_v   = (a[15] == b[15]) && (add_res[15] != a[15]);
    assign sub_v   = (a[15] != b[15]) && (sub_res[15] != a[15]);
    assign red_sum = {{2{a[15]}}, a[15:8]} + {{2{a[7]}}, a[7:0]}
                   + {{2{b[15]}}, b[15:8]} + {{2{b[7]}}, b[7:0]};
    assign rot_wide = {a, a} >> sh;

    always_comb begin
        paddsb_res = '0;
        for (int i = 0; i < 4; i++) begin
            paddsb_res[4*i +: 4] = sat_add4(a[4*i +: 4], b[4*i +: 4]);
        end
    end

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        result = '0;
        v      = 1'b0;
        err    = 1'b0;
        case (op)
            OP_ADD:    begin result = add_res; v = add_v; end
            OP_SUB:    begin result = sub_res; v = sub_v; end
            OP_XOR:    result = a ^ b;
            OP_RED:    result = {{6{red_sum[9]}}, red_sum};
            OP_SLL:    result = a << sh;
            OP_SRA:    result = $signed(a) >>> sh;
            OP_ROR:    result = rot_wide[15:0];
            OP_PADDSB: result = paddsb_res;
            OP_LW,
            OP_SW:     result = a + b;  // memory address: base + offset
            OP_LLB:    result = {a[15:8], b[7:0]};
            OP_LHB:    result = {b[7:0], a[7:0]};
            default:   err = 1'b1;
        endcase
    end

    assign alu_flags = {result[15], (result == '0), v};

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU with a one-entry response slot and flag register.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_err,
    output logic [2:0]        flags
);

    logic              rsp_valid_q,  rsp_valid_d;
    logic              rsp_id_q,     rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_err_q,    rsp_err_d;
    logic [2:0]        flags_q,      flags_d;
    logic              last_grant_q, last_grant_d;

    logic              slot_free;
    logic              gnt0, gnt1;
    logic              acc0, acc1, accept;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [OP_W-1:0]   alu_op;
    logic [2:0]        alu_flags;
    logic              alu_err;

    assign slot_free = !rsp_valid_q || rsp_ready;

    // On a tie, round-robin favours whichever requester was not granted last.
    assign gnt1 = req1_valid && (!req0_valid || (RR_EN && !last_grant_q));
    assign gnt0 = req0_valid && !gnt1;
    assign acc0 = slot_free && gnt0;
    assign acc1 = slot_free && gnt1;
    assign accept = acc0 || acc1;

    assign req0_ready = rst_n && acc0;
    assign req1_ready = rst_n && acc1;

    assign alu_a  = gnt1 ? req1_a  : req0_a;
    assign alu_b  = gnt1 ? req1_b  : req0_b;
    assign alu_op = gnt1 ? req1_op : req0_op;

    alu u_alu (
        .a         (alu_a),
        .b         (alu_b),
        .op        (alu_op),
        .result    (alu_result),
        .alu_flags (alu_flags),
        .err       (alu_err)
    );

    always_comb begin
        rsp_valid_d  = rsp_valid_q && !rsp_ready;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        flags_d      = flags_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt1;
            rsp_result_d = alu_result;
            rsp_err_d    = alu_err;
            last_grant_d = gnt1;
            if (!alu_err) begin
                if (is_nv_op(alu_op)) begin
                    flags_d = alu_flags;
                end else if (is_z_op(alu_op)) begin
                    flags_d[FLAG_Z] = alu_flags[FLAG_Z];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            flags_q      <= 3'b000;
            last_grant_q <= 1'b1;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            flags_q      <= flags_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_err    = rsp_err_q;
    assign flags      = flags_q;

endmodule
